// File: rtl/traceback_formatter.sv
// traceback_formatter: turns the end-to-start {x, y} cell stream of a
// Needleman-Wunsch traceback walker into aligned column pairs. Columns are
// pushed onto a LIFO and replayed in forward order.
// Ports:
//   clk, reset             clock, asynchronous active-low reset
//   s1, s2                 packed strings (char j at the MSB end for j=0)
//   in_valid/in_ready      coordinate handshake, in_x/in_y/in_last payload
//   out_valid/out_ready    column handshake
//   out_c1/out_c2          characters, out_gap1/out_gap2 gap flags
//   out_last, out_len      final column marker, total column count
//   error                  sticky protocol error
module traceback_formatter #(
   parameter int unsigned LENGTH      = 10,
   parameter int unsigned CWIDTH      = 2,
   parameter int unsigned CORD_LENGTH = 8,
   parameter int unsigned DEPTH       = 2*LENGTH-1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [LENGTH*CWIDTH-1:0] s1,
   input  logic [LENGTH*CWIDTH-1:0] s2,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [CORD_LENGTH-1:0]   in_x,
   input  logic [CORD_LENGTH-1:0]   in_y,
   input  logic                     in_last,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [CWIDTH-1:0]        out_c1,
   output logic [CWIDTH-1:0]        out_c2,
   output logic                     out_gap1,
   output logic                     out_gap2,
   output logic                     out_last,
   output logic [CORD_LENGTH:0]     out_len,
   output logic                     error
);
   localparam int unsigned SW    = LENGTH*CWIDTH;
   localparam int unsigned CNT_W = $clog2(DEPTH+1);
   localparam int unsigned LEN_W = CORD_LENGTH+1;
   localparam logic [CORD_LENGTH-1:0] LAST_C = CORD_LENGTH'(LENGTH-1);

   typedef struct packed {
      logic [CWIDTH-1:0] c1;
      logic [CWIDTH-1:0] c2;
      logic              gap1;
      logic              gap2;
   } col_t;

   typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_FINAL, S_DRAIN, S_ERROR} state_t;

   state_t                 state_q, state_d;
   logic [CORD_LENGTH-1:0] px_q, px_d, py_q, py_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [LEN_W-1:0]       len_q, len_d;
   logic                   err_q, err_d;
   logic                   in_ready_q, in_ready_d;
   logic                   out_valid_q, out_valid_d;
   logic                   out_last_q, out_last_d;
   col_t                   out_q, out_d;
   col_t                   stack_q [DEPTH];
   logic                   push_en;
   col_t                   push_col;
   col_t                   step_col;
   logic                   step_ok;
   logic                   in_fire;

   // Character j of a packed string; out-of-range indices read as 0.
   function automatic logic [CWIDTH-1:0] chr(input logic [SW-1:0] s,
                                             input logic [CORD_LENGTH-1:0] idx);
      chr = '0;
      for (int j = 0; j < int'(LENGTH); j++)
         if (idx == CORD_LENGTH'(j)) chr = s[(int'(LENGTH)-1-j)*int'(CWIDTH) +: CWIDTH];
   endfunction

   assign in_fire = in_valid && in_ready_q;

   // Classify the step from the pending cell to the incoming one.
   // Zero guards stop a decrement from wrapping to a legal-looking value.
   always_comb begin
      step_col = '0;
      step_ok  = 1'b1;
      if (px_q != '0 && py_q != '0 &&
          in_x == px_q - CORD_LENGTH'(1) && in_y == py_q - CORD_LENGTH'(1)) begin
         step_col.c1 = chr(s1, py_q);
         step_col.c2 = chr(s2, px_q);
      end else if (py_q != '0 && in_x == px_q && in_y == py_q - CORD_LENGTH'(1)) begin
         step_col.c1   = chr(s1, py_q);
         step_col.gap2 = 1'b1;
      end else if (px_q != '0 && in_x == px_q - CORD_LENGTH'(1) && in_y == py_q) begin
         step_col.c2   = chr(s2, px_q);
         step_col.gap1 = 1'b1;
      end else begin
         step_ok = 1'b0;
      end
   end

   // Next-state and output logic. An error raised by a coordinate that also
   // carries in_last ends the traceback, so it returns straight to IDLE.
   always_comb begin
      state_d     = state_q;
      px_d        = px_q;
      py_d        = py_q;
      cnt_d       = cnt_q;
      len_d       = len_q;
      err_d       = err_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      push_en     = 1'b0;
      push_col    = '0;
      case (state_q)
         S_IDLE: begin
            if (in_fire) begin
               if (in_x == LAST_C && in_y == LAST_C && (!in_last || LENGTH == 1)) begin
                  px_d    = in_x;
                  py_d    = in_y;
                  err_d   = 1'b0;
                  cnt_d   = '0;
                  state_d = in_last ? S_FINAL : S_COLLECT;
               end else begin
                  err_d   = 1'b1;
                  state_d = in_last ? S_IDLE : S_ERROR;
               end
            end
         end
         S_COLLECT: begin
            if (in_fire) begin
               if (!step_ok || cnt_q == CNT_W'(DEPTH) ||
                   (in_last && (in_x != '0 || in_y != '0))) begin
                  err_d   = 1'b1;
                  cnt_d   = '0;
                  state_d = in_last ? S_IDLE : S_ERROR;
               end else begin
                  push_en  = 1'b1;
                  push_col = step_col;
                  cnt_d    = cnt_q + CNT_W'(1);
                  px_d     = in_x;
                  py_d     = in_y;
                  state_d  = in_last ? S_FINAL : S_COLLECT;
               end
            end
         end
         S_FINAL: begin
            // (0,0) cell is always a corner; its column is also the first output.
            if (cnt_q == CNT_W'(DEPTH)) begin
               err_d   = 1'b1;
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               push_en       = 1'b1;
               push_col.c1   = chr(s1, '0);
               push_col.c2   = chr(s2, '0);
               cnt_d         = cnt_q + CNT_W'(1);
               len_d         = LEN_W'(cnt_q) + LEN_W'(1);
               out_d         = push_col;
               out_valid_d   = 1'b1;
               out_last_d    = (cnt_q == '0);
               state_d       = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (out_valid_q && out_ready) begin
               cnt_d = cnt_q - CNT_W'(1);
               if (out_last_q) begin
                  out_d       = '0;
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  len_d       = '0;
                  state_d     = S_IDLE;
               end else begin
                  // Entry below the current top becomes the new top.
                  out_d      = stack_q[cnt_q - CNT_W'(2)];
                  out_last_d = (cnt_q == CNT_W'(2));
               end
            end
         end
         S_ERROR: begin
            if (in_fire && in_last) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      in_ready_d = !(state_d == S_FINAL || state_d == S_DRAIN);
   end

   // Control and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         px_q        <= '0;
         py_q        <= '0;
         cnt_q       <= '0;
         len_q       <= '0;
         err_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_q       <= '0;
      end else begin
         state_q     <= state_d;
         px_q        <= px_d;
         py_q        <= py_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         err_q       <= err_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_q       <= out_d;
      end
   end

   // Stack storage; contents are meaningless once cnt_q is cleared.
   always_ff @(posedge clk) begin
      if (push_en) stack_q[cnt_q] <= push_col;
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_c1    = out_q.c1;
   assign out_c2    = out_q.c2;
   assign out_gap1  = out_q.gap1;
   assign out_gap2  = out_q.gap2;
   assign out_last  = out_last_q;
   assign out_len   = len_q;
   assign error     = err_q;
endmodule
